// File: rtl/spi_master_tb_if.sv
// SPI master bus bundle: host-side controls/status plus the four SPI wires.
// The master modport is the SPI master; the slave modport is its user/peer.
`ifndef MSB
`define MSB 1'b1
`endif
`ifndef LSB
`define LSB 1'b0
`endif

interface spi_master_tb_if #(
   parameter int BITS_PER_FRAME = 8
);
   logic                      Enable_i;
   logic                      start_i;
   logic                      abort_i;
   logic [BITS_PER_FRAME-1:0] tx_data_i;
   logic [BITS_PER_FRAME-1:0] rx_data_o;
   logic                      nCS_o;
   logic                      SCLK_o;
   logic                      SDO_o;
   logic                      SDI_i;
   logic                      busy_o;
   logic                      data_ready_o;
   logic                      abort_o;
   logic [15:0]               bits_wr_cnt_o;
   logic [15:0]               bits_rd_cnt_o;

   modport master (
      input  Enable_i, start_i, abort_i, tx_data_i, SDI_i,
      output rx_data_o, nCS_o, SCLK_o, SDO_o, busy_o,
      output data_ready_o, abort_o, bits_wr_cnt_o, bits_rd_cnt_o
   );

   modport slave (
      output Enable_i, start_i, abort_i, tx_data_i, SDI_i,
      input  rx_data_o, nCS_o, SCLK_o, SDO_o, busy_o,
      input  data_ready_o, abort_o, bits_wr_cnt_o, bits_rd_cnt_o
   );
endinterface

// File: rtl/spi_master_tb.sv
// Clocked SPI master: frames nCS/SCLK/SDO, samples SDI, supports aborts.
// All outputs are registered; one FSM sequences setup, shift, hold and gap.
module spi_master_tb #(
   parameter int BITS_PER_FRAME = 8,
   parameter bit FIRST_BIT      = `MSB,
   parameter bit CPOL           = 1'b0,
   parameter bit CPHA           = 1'b0,
   parameter int CLK_DIV        = 2,
   parameter int NCS_SETUP_CLKS = 2,
   parameter int NCS_HOLD_CLKS  = 2,
   parameter int NCS_IDLE_CLKS  = 4
) (
   input  logic           clk_i,
   input  logic           nReset_i,
   spi_master_tb_if.master bus
);
   localparam int W     = BITS_PER_FRAME;
   localparam int EDGES = 2 * W;
   localparam int EW    = $clog2(EDGES + 1);
   // DONE is the first gap cycle, so GAP itself runs one cycle less.
   localparam int GAP_N = NCS_IDLE_CLKS - 1;

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_XFER, S_HOLD, S_DONE, S_GAP, S_ABRT
   } state_e;

   state_e        state_q;
   logic [15:0]   tmr_q;
   logic [EW-1:0] edg_q;
   logic [W-1:0]  sh_q, rx_q, rxo_q;
   logic          ncs_q, sclk_q, sdo_q, busy_q, dr_q, ab_q;
   logic [15:0]   wr_q, rd_q, wro_q, rdo_q;

   function automatic logic [W-1:0] rev(input logic [W-1:0] v);
      logic [W-1:0] r;
      for (int i = 0; i < W; i++) r[i] = v[W-1-i];
      return r;
   endfunction

   function automatic logic [15:0] sat(input logic [15:0] c);
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction

   logic [W-1:0]  ord_tx;
   logic [EW-1:0] edg_n;
   logic          tick, last, kill, samp, shft;

   always_comb begin
      ord_tx = FIRST_BIT ? bus.tx_data_i : rev(bus.tx_data_i);
      edg_n  = edg_q + 1'b1;
      tick   = (tmr_q == 16'(CLK_DIV - 1));
      last   = (edg_n == EW'(EDGES));
      kill   = (bus.abort_i || !bus.Enable_i) &&
               (state_q inside {S_SETUP, S_XFER, S_HOLD});
      samp   = CPHA ? !edg_n[0] : edg_n[0];
      shft   = CPHA ? edg_n[0] : (!edg_n[0] && !last);
   end

   always_ff @(posedge clk_i or negedge nReset_i) begin
      if (!nReset_i) begin
         state_q <= S_IDLE;
         tmr_q   <= '0;
         edg_q   <= '0;
         sh_q    <= '0;
         rx_q    <= '0;
         rxo_q   <= '0;
         ncs_q   <= 1'b1;
         sclk_q  <= CPOL;
         sdo_q   <= 1'b0;
         busy_q  <= 1'b0;
         dr_q    <= 1'b0;
         ab_q    <= 1'b0;
         wr_q    <= '0;
         rd_q    <= '0;
         wro_q   <= '0;
         rdo_q   <= '0;
      end else begin
         dr_q <= 1'b0;
         ab_q <= 1'b0;
         if (kill) begin
            state_q <= S_ABRT;
            ncs_q   <= 1'b1;
            sclk_q  <= CPOL;
            sdo_q   <= 1'b0;
            ab_q    <= 1'b1;
            wro_q   <= wr_q;
            rdo_q   <= rd_q;
         end else begin
            unique case (state_q)
               S_IDLE: begin
                  if (bus.start_i && bus.Enable_i) begin
                     state_q <= S_SETUP;
                     busy_q  <= 1'b1;
                     ncs_q   <= 1'b0;
                     tmr_q   <= '0;
                     edg_q   <= '0;
                     rx_q    <= '0;
                     rd_q    <= '0;
                     if (!CPHA) begin
                        sdo_q <= ord_tx[W-1];
                        sh_q  <= ord_tx << 1;
                        wr_q  <= 16'd1;
                     end else begin
                        sdo_q <= 1'b0;
                        sh_q  <= ord_tx;
                        wr_q  <= '0;
                     end
                  end
               end
               S_SETUP: begin
                  if (tmr_q == 16'(NCS_SETUP_CLKS - 1)) begin
                     state_q <= S_XFER;
                     tmr_q   <= '0;
                  end else begin
                     tmr_q <= tmr_q + 16'd1;
                  end
               end
               S_XFER: begin
                  if (tick) begin
                     tmr_q  <= '0;
                     sclk_q <= ~sclk_q;
                     edg_q  <= edg_n;
                     if (samp) begin
                        rx_q <= (rx_q << 1) | W'(bus.SDI_i);
                        rd_q <= sat(rd_q);
                     end
                     if (shft) begin
                        sdo_q <= sh_q[W-1];
                        sh_q  <= sh_q << 1;
                        wr_q  <= sat(wr_q);
                     end
                     if (last) state_q <= S_HOLD;
                  end else begin
                     tmr_q <= tmr_q + 16'd1;
                  end
               end
               S_HOLD: begin
                  if (tmr_q == 16'(NCS_HOLD_CLKS - 1)) begin
                     state_q <= S_DONE;
                     tmr_q   <= '0;
                     ncs_q   <= 1'b1;
                     sdo_q   <= 1'b0;
                     dr_q    <= 1'b1;
                     rxo_q   <= FIRST_BIT ? rx_q : rev(rx_q);
                     wro_q   <= wr_q;
                     rdo_q   <= rd_q;
                  end else begin
                     tmr_q <= tmr_q + 16'd1;
                  end
               end
               S_DONE, S_ABRT: begin
                  tmr_q <= '0;
                  if (GAP_N <= 0) begin
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= S_GAP;
                  end
               end
               S_GAP: begin
                  if (tmr_q == 16'(GAP_N - 1)) begin
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     tmr_q <= tmr_q + 16'd1;
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.nCS_o         = ncs_q;
   assign bus.SCLK_o        = sclk_q;
   assign bus.SDO_o         = sdo_q;
   assign bus.busy_o        = busy_q;
   assign bus.data_ready_o  = dr_q;
   assign bus.abort_o       = ab_q;
   assign bus.rx_data_o     = rxo_q;
   assign bus.bits_wr_cnt_o = wro_q;
   assign bus.bits_rd_cnt_o = rdo_q;
endmodule
